// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader and its byte packer:
// FSM state encoding, word geometry and the little-endian byte insert helper.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  // CHECK is only reachable when the checksum trailer is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    FINISH  = 3'd3,
    CHECK   = 3'd4
  } state_e;

  // Shift a new byte in from the top: after WORD_BYTES shifts the first
  // byte received sits in bits [7:0] (little-endian packing).
  function automatic logic [INSTR_W-1:0] pack_byte(
    input logic [INSTR_W-1:0] sr,
    input logic [7:0]         b
  );
    return {b, sr[INSTR_W-1:8]};
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_byte_packer
// Packs a stream of accepted bytes into 32-bit little-endian words.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   clear      in   synchronous clear of byte counter and shift register
//   in_valid   in   a byte is accepted this cycle
//   in_data    in   accepted byte
//   word_valid out  this cycle's byte completes a word (combinational)
//   word       out  completed word, valid together with word_valid
// ---------------------------------------------------------------------------
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  localparam logic [BYTE_IDX_W-1:0] CNT_ONE  = BYTE_IDX_W'(1'b1);
  localparam logic [BYTE_IDX_W-1:0] CNT_LAST = BYTE_IDX_W'(WORD_BYTES - 1);

  logic [BYTE_IDX_W-1:0] cnt_q, cnt_d;
  logic [INSTR_W-1:0]    sr_q,  sr_d;

  // Word assembly and next-state of the byte counter / shift register.
  always_comb begin
    word       = pack_byte(sr_q, in_data);
    word_valid = in_valid && (cnt_q == CNT_LAST);
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (in_valid) begin
      // Counter wraps to 0 after the last byte, ready for the next word.
      cnt_d = cnt_q + CNT_ONE;
      sr_d  = word;
    end else begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
    end
  end

  // Byte counter and shift register flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a byte stream from a host/debug link into instruction memory as
// little-endian 32-bit words at consecutive addresses starting at BASE_ADDR,
// holding the core in reset (cpu_hold) until the load completes.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): after the last data word
// four trailer bytes carry the expected 32-bit wrap-around sum of all written
// words; a mismatch sets error and keeps cpu_hold asserted.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   load_start  in   pulse starting a load (honoured only in IDLE)
//   load_len    in   words to load, sampled with load_start
//   byte_valid  in   byte_data valid
//   byte_data   in   incoming byte
//   byte_ready  out  loader accepts a byte this cycle
//   wr_en       out  one-cycle memory write strobe per word
//   wr_addr     out  byte address of the write
//   wr_data     out  assembled word
//   cpu_hold    out  keeps the core in reset
//   busy        out  load in progress
//   done        out  one-cycle completion pulse (also for rejected loads)
//   error       out  sticky error, cleared by next load_start or reset
// All outputs are registered.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          LEN_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [LEN_W-1:0]   load_len,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [31:0]        wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MAX_WORDS);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_q, sum_d;
`endif

  logic               pack_clr_s;
  logic               pack_valid_s;
  logic               word_valid_s;
  logic [INSTR_W-1:0] word_s;
  logic               len_bad_s;
  logic               rej_done_s;

  // A byte moves only when the registered ready and the host valid agree.
  assign pack_valid_s = byte_valid && byte_ready_q;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clr_s),
    .in_valid   (pack_valid_s),
    .in_data    (byte_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state logic for the load FSM, counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    error_d    = error_q;
    pack_clr_s = 1'b0;
    rej_done_s = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    len_bad_s  = (load_len == {LEN_W{1'b0}}) || ({1'b0, load_len} > MAX_LEN);

    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_bad_s) begin
            // Rejected: flag and pulse done, hold state unchanged.
            error_d    = 1'b1;
            rej_done_s = 1'b1;
          end else begin
            len_d      = load_len;
            word_cnt_d = '0;
            wr_addr_d  = BASE_ADDR;
            error_d    = 1'b0;
            cpu_hold_d = 1'b1;
            pack_clr_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
            state_d    = COLLECT;
          end
        end else begin
          state_d = IDLE;
        end
      end

      COLLECT: begin
        if (word_valid_s) begin
          wr_data_d = word_s;
          state_d   = WRITE;
        end else begin
          state_d = COLLECT;
        end
      end

      WRITE: begin
        // wr_en is high this cycle; address/count advance afterwards.
        word_cnt_d = word_cnt_q + LEN_ONE;
        wr_addr_d  = wr_addr_q + 32'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + wr_data_q;
`endif
        if (word_cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d    = CHECK;
`else
          cpu_hold_d = 1'b0;
          state_d    = FINISH;
`endif
        end else begin
          state_d = COLLECT;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        // Trailer bytes go through the packer but are never written.
        if (word_valid_s) begin
          if (word_s != sum_q) begin
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end else begin
            cpu_hold_d = 1'b0;
          end
          state_d = FINISH;
        end else begin
          state_d = CHECK;
        end
      end
`endif

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    byte_ready_d = (state_d == COLLECT) || (state_d == CHECK);
    wr_en_d      = (state_d == WRITE);
    busy_d       = (state_d == COLLECT) || (state_d == WRITE) || (state_d == CHECK);
    done_d       = rej_done_s || (state_d == FINISH);
  end

  // State, counters and output registers; cpu_hold powers up asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      wr_addr_q    <= 32'h0000_0000;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs change and outputs are
// sampled on the falling clock edge. A logger records every write and done
// pulse so the directed sequence can compare against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] load_len = 16'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, wr_en, cpu_hold, busy, done, error;
  logic [31:0] wr_addr, wr_data;

  int total = 0;
  int passed = 0;
  int wr_n = 0;
  int done_n = 0;
  int wbase, dbase;
  logic [31:0] wa_log [16];
  logic [31:0] wd_log [16];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Record each write cycle and each done pulse.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_n < 16) begin
        wa_log[wr_n] = wr_addr;
        wd_log[wr_n] = wr_data;
      end
      wr_n = wr_n + 1;
    end
    if (done === 1'b1) done_n = done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_load(input logic [15:0] len);
    load_len   = len;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_trailer(input logic [31:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum, 0);
`else
    if (sum == 32'hFFFF_FFFF) @(negedge clk);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    // Reset for two cycles.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-word load: 13 00 00 00 93 00 10 00.
    wbase = wr_n; dbase = done_n;
    start_load(16'd2);
    check("l2_busy", 32'(busy), 32'd1);
    check("l2_hold", 32'(cpu_hold), 32'd1);
    check("l2_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_trailer(32'h0010_00A6);
    wait_done("l2_done");
    check("l2_hold_rel", 32'(cpu_hold), 32'd0);
    check("l2_busy_end", 32'(busy), 32'd0);
    check("l2_error", 32'(error), 32'd0);
    @(negedge clk);
    check("l2_done_pulse", 32'(done), 32'd0);
    check("l2_nwr", 32'(wr_n - wbase), 32'd2);
    check("l2_addr0", wa_log[wbase], 32'h0000_0000);
    check("l2_data0", wd_log[wbase], 32'h0000_0013);
    check("l2_addr1", wa_log[wbase+1], 32'h0000_0004);
    check("l2_data1", wd_log[wbase+1], 32'h0010_0093);
    check("l2_ndone", 32'(done_n - dbase), 32'd1);

    // One word, byte_valid every other cycle: EF BE AD DE.
    wbase = wr_n;
    start_load(16'd1);
    send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1);
    byte_valid = 1'b1; byte_data = 8'hDE;
    @(negedge clk);
    byte_valid = 1'b0;
    check("l1_wr_en_lat", 32'(wr_en), 32'd1);
    check("l1_wr_data", wr_data, 32'hDEAD_BEEF);
    check("l1_wr_addr", wr_addr, 32'h0000_0000);
    check("l1_ready_wr", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("l1_wr_en_one", 32'(wr_en), 32'd0);
    send_trailer(32'hDEAD_BEEF);
    wait_done("l1_done");
    @(negedge clk);
    check("l1_nwr", 32'(wr_n - wbase), 32'd1);

    // Invalid lengths: 0 and MAX_WORDS+1.
    wbase = wr_n; dbase = done_n;
    start_load(16'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_error", 32'(error), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_hold", 32'(cpu_hold), 32'd0);
    check("len0_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("len0_done_off", 32'(done), 32'd0);
    check("len0_err_sticky", 32'(error), 32'd1);
    start_load(16'd257);
    check("len257_done", 32'(done), 32'd1);
    check("len257_error", 32'(error), 32'd1);
    check("len257_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("badlen_nwr", 32'(wr_n - wbase), 32'd0);
    check("badlen_ndone", 32'(done_n - dbase), 32'd2);

    // load_start while busy is ignored: 01 02 03 04.
    wbase = wr_n;
    start_load(16'd1);
    check("busy_err_clr", 32'(error), 32'd0);
    check("busy_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    start_load(16'd0);
    check("busy_ign_err", 32'(error), 32'd0);
    check("busy_ign_busy", 32'(busy), 32'd1);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_trailer(32'h0403_0201);
    wait_done("busy_done");
    @(negedge clk);
    check("busy_nwr", 32'(wr_n - wbase), 32'd1);
    check("busy_addr", wa_log[wbase], 32'h0000_0000);
    check("busy_data", wd_log[wbase], 32'h0403_0201);

    // Reset after 2 bytes of a 3-word load.
    wbase = wr_n; dbase = done_n;
    start_load(16'd3);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_hold", 32'(cpu_hold), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    check("abort_nwr", 32'(wr_n - wbase), 32'd0);
    check("abort_ndone", 32'(done_n - dbase), 32'd0);
    start_load(16'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_trailer(32'h4433_2211);
    wait_done("reload_done");
    @(negedge clk);
    check("reload_nwr", 32'(wr_n - wbase), 32'd1);
    check("reload_addr", wa_log[wbase], 32'h0000_0000);
    check("reload_data", wd_log[wbase], 32'h4433_2211);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match: words 1, 2, trailer 03 00 00 00.
    wbase = wr_n;
    start_load(16'd2);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_done("ck_ok_done");
    check("ck_ok_error", 32'(error), 32'd0);
    check("ck_ok_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("ck_ok_nwr", 32'(wr_n - wbase), 32'd2);
    // Checksum mismatch: trailer 04 00 00 00.
    start_load(16'd2);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_done("ck_bad_done");
    check("ck_bad_error", 32'(error), 32'd1);
    check("ck_bad_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("ck_bad_hold_idle", 32'(cpu_hold), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
